// File: rtl/spi_rgb_cmd.sv
`default_nettype none
// ============================================================================
// Module      : spi_rgb_cmd
// Description : Parses framed SPI command bytes into speed, restart, mode and
//               static RGB colour controls for the LED colour-cycle engines.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rgb_cmd #(
    parameter logic [19:0] DEFAULT_SPEED = 20'd4095,
    parameter int unsigned RST_PULSE_LEN = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_spi_start,
    input  logic        i_spi_end,
    input  logic        i_spi_stb,
    input  logic [7:0]  i_spi_data,
    output logic [19:0] o_speed,
    output logic        o_cycle_rst,
    output logic        o_mode,
    output logic [7:0]  o_r,
    output logic [7:0]  o_g,
    output logic [7:0]  o_b,
    output logic [7:0]  o_err_cnt,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPC  = 2'd1,
        S_PAY  = 2'd2,
        S_SKIP = 2'd3
    } state_t;

    localparam logic [1:0] c_OP_SPEED = 2'd0;
    localparam logic [1:0] c_OP_COLOR = 2'd1;
    localparam logic [1:0] c_OP_MODE  = 2'd2;
    localparam logic [7:0] c_PULSE    = 8'(RST_PULSE_LEN);

    state_t      r_state, w_state;
    logic [1:0]  r_op, w_op;
    logic [1:0]  r_idx, w_idx;
    logic [1:0]  w_last;
    logic [7:0]  r_sh0, w_sh0;
    logic [7:0]  r_sh1, w_sh1;
    logic [19:0] r_speed, w_speed;
    logic        r_mode, w_mode;
    logic [7:0]  r_r, w_r;
    logic [7:0]  r_g, w_g;
    logic [7:0]  r_b, w_b;
    logic [7:0]  r_err, w_err;
    logic [1:0]  w_err_inc;
    logic [8:0]  w_err_sum;
    logic [7:0]  r_rst_cnt, w_rst_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_op      <= c_OP_SPEED;
            r_idx     <= 2'd0;
            r_sh0     <= 8'd0;
            r_sh1     <= 8'd0;
            r_speed   <= DEFAULT_SPEED;
            r_mode    <= 1'b0;
            r_r       <= 8'd0;
            r_g       <= 8'd0;
            r_b       <= 8'd0;
            r_err     <= 8'd0;
            r_rst_cnt <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_op      <= w_op;
            r_idx     <= w_idx;
            r_sh0     <= w_sh0;
            r_sh1     <= w_sh1;
            r_speed   <= w_speed;
            r_mode    <= w_mode;
            r_r       <= w_r;
            r_g       <= w_g;
            r_b       <= w_b;
            r_err     <= w_err;
            r_rst_cnt <= w_rst_cnt;
        end
    end

    // Same-cycle events are applied in order start, byte, end on the working copy.
    always_comb begin
        w_state   = r_state;
        w_op      = r_op;
        w_idx     = r_idx;
        w_sh0     = r_sh0;
        w_sh1     = r_sh1;
        w_speed   = r_speed;
        w_mode    = r_mode;
        w_r       = r_r;
        w_g       = r_g;
        w_b       = r_b;
        w_err_inc = 2'd0;
        w_rst_cnt = (r_rst_cnt != 8'd0) ? r_rst_cnt - 8'd1 : 8'd0;
        w_last    = 2'd0;

        if (i_spi_start) begin
            if (r_state == S_PAY) w_err_inc = w_err_inc + 2'd1;
            w_state = S_OPC;
            w_idx   = 2'd0;
        end

        if (i_spi_stb) begin
            case (w_state)
                S_OPC: begin
                    w_idx = 2'd0;
                    case (i_spi_data)
                        8'h10: begin w_op = c_OP_SPEED; w_state = S_PAY; end
                        8'h11: begin w_op = c_OP_COLOR; w_state = S_PAY; end
                        8'h12: begin w_op = c_OP_MODE;  w_state = S_PAY; end
                        8'h13: begin w_rst_cnt = c_PULSE; w_state = S_SKIP; end
                        default: begin
                            w_err_inc = w_err_inc + 2'd1;
                            w_state   = S_SKIP;
                        end
                    endcase
                end
                S_PAY: begin
                    w_last = (w_op == c_OP_MODE) ? 2'd0 : 2'd2;
                    if (w_idx == w_last) begin
                        // Last byte taken straight from the bus so all fields land together.
                        case (w_op)
                            c_OP_SPEED: w_speed = {r_sh0[3:0], r_sh1, i_spi_data};
                            c_OP_COLOR: begin
                                w_r = r_sh0;
                                w_g = r_sh1;
                                w_b = i_spi_data;
                            end
                            default:    w_mode = i_spi_data[0];
                        endcase
                        w_state = S_SKIP;
                    end else begin
                        if (w_idx == 2'd0) w_sh0 = i_spi_data;
                        else               w_sh1 = i_spi_data;
                        w_idx = w_idx + 2'd1;
                    end
                end
                default: ;
            endcase
        end

        if (i_spi_end) begin
            if (w_state == S_PAY) w_err_inc = w_err_inc + 2'd1;
            w_state = S_IDLE;
        end

        w_err_sum = {1'b0, r_err} + {7'd0, w_err_inc};
        w_err     = w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
    end

    assign o_speed     = r_speed;
    assign o_cycle_rst = (r_rst_cnt != 8'd0);
    assign o_mode      = r_mode;
    assign o_r         = r_r;
    assign o_g         = r_g;
    assign o_b         = r_b;
    assign o_err_cnt   = r_err;
    assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
